mca_s_frame_ctrl: RTL and testbench

//  Upstream feeder for the single-AS multi-clock LUT adder tree. Collects the serial control-bit

---
 rtl/mca_s_frame_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mca_s_frame_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mca_s_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mca_s_frame_ctrl
//  Description : Frame controller feeding the single-AS multi-clock LUT adder
//                tree. It shifts the serial control bits into a K-bit window
//                and snapshots the window every DECIMATION accepted bits. Each
//                snapshot is held for MCA_NUM_ADDITIONS cycles and marked by a
//                one-cycle start pulse. Start pulses are delayed by
//                RESULT_LATENCY cycles to form sample_valid. A frame that
//                falls due while a snapshot is still held is dropped and
//                raises the sticky overrun flag.
//  Options     : MCA_FRAME_STATS_EN adds the frame_cnt and drop_cnt counters
//                and their output ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module mca_s_frame_ctrl #(
  parameter int K                 = 256,
  parameter int MCA_NUM_ADDITIONS = 16,
  parameter int DECIMATION        = 32,
  parameter int RESULT_LATENCY    = 34
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         s_in,
  input  logic         s_valid,
`ifdef MCA_FRAME_STATS_EN
  output logic [31:0]  frame_cnt,
  output logic [15:0]  drop_cnt,
`endif
  output logic [K-1:0] S_matrix,
  output logic         start,
  output logic         busy,
  output logic         sample_valid,
  output logic         overrun
);

  localparam int c_FW = $clog2(K + 1);
  localparam int c_DW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int c_HW = (MCA_NUM_ADDITIONS > 1) ? $clog2(MCA_NUM_ADDITIONS) : 1;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [K-1:0]        r_win;
  logic [K-1:0]        w_win_nxt;
  logic [c_FW-1:0]     r_fill_cnt;
  logic [c_DW-1:0]     r_dec_cnt;
  logic [c_HW-1:0]     r_hold_cnt;
  logic [K-1:0]        r_snap;
  logic                r_start;
  logic                r_overrun;
  logic [RESULT_LATENCY-1:0] r_lat;

  logic w_full_now;
  logic w_due;
  logic w_can_take;
  logic w_issue;
  logic w_drop;
  logic w_busy;

  // The window shifted by the current bit; used for both the window update
  // and the snapshot so that the triggering bit is part of the frame.
  assign w_win_nxt  = {r_win[K-2:0], s_in};

  // Full either already, or made full by the bit accepted this cycle (that
  // bit counts as the first decimation bit).
  assign w_full_now = (r_fill_cnt == c_FW'(K)) ||
                      (s_valid && (r_fill_cnt == c_FW'(K - 1)));
  assign w_due      = s_valid && w_full_now && (r_dec_cnt == c_DW'(DECIMATION - 1));

  // The last RUN cycle may accept a new frame so frames can run back-to-back.
  assign w_can_take = (r_state != ST_RUN) || (r_hold_cnt == '0);
  assign w_issue    = w_due && w_can_take;
  assign w_drop     = w_due && !w_can_take;

  // Window, fill and decimation counters advance on every accepted bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_win      <= '0;
      r_fill_cnt <= '0;
      r_dec_cnt  <= '0;
    end else if (s_valid) begin
      r_win <= w_win_nxt;
      if (r_fill_cnt != c_FW'(K)) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      if (w_full_now) begin
        r_dec_cnt <= (r_dec_cnt == c_DW'(DECIMATION - 1)) ? '0 : r_dec_cnt + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and busy decode.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_issue) begin
          w_state_nxt = ST_RUN;
        end else if (w_full_now) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_hold_cnt == '0) begin
          w_state_nxt = w_issue ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  // Hold counter: loaded on a new frame, counts down while the frame is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold_cnt <= '0;
    end else if (w_issue) begin
      r_hold_cnt <= c_HW'(MCA_NUM_ADDITIONS - 1);
    end else if ((r_state == ST_RUN) && (r_hold_cnt != '0)) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // Snapshot, start pulse and sticky overrun flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_snap    <= '0;
      r_start   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_start   <= w_issue;
      r_overrun <= r_overrun | w_drop;
      if (w_issue) begin
        r_snap <= w_win_nxt;
      end
    end
  end

  // Latency pipe: start pulses travel RESULT_LATENCY stages to sample_valid.
  generate
    if (RESULT_LATENCY == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_lat <= '0;
        end else begin
          r_lat <= r_start;
        end
      end
    end else begin : g_lat_pipe
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_lat <= '0;
        end else begin
          r_lat <= {r_lat[RESULT_LATENCY-2:0], r_start};
        end
      end
    end
  endgenerate

`ifdef MCA_FRAME_STATS_EN
  logic [31:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  // Issued and dropped frame counters; both wrap on overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_issue) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

  assign S_matrix     = r_snap;
  assign start        = r_start;
  assign busy         = w_busy;
  assign sample_valid = r_lat[RESULT_LATENCY-1];
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mca_s_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mca_s_frame_ctrl
//  Description : Scoreboard bench for mca_s_frame_ctrl. Two instances run side
//                by side: DECIMATION=8 (normal) and DECIMATION=2 (overrun).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mca_s_frame_ctrl;

  localparam int K  = 16;
  localparam int A  = 4;
  localparam int D0 = 8;
  localparam int D1 = 2;
  localparam int L  = 10;

  typedef struct {
    logic [K-1:0] snap;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         s_in = 1'b0;
  logic         s_valid = 1'b0;

  logic [K-1:0] s0_S, s1_S;
  logic         s0_start, s1_start, s0_busy, s1_busy;
  logic         s0_sv, s1_sv, s0_ovr, s1_ovr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state (shared bit history, per-instance frame tracking).
  bit   hist[$];
  int   n_acc;
  int   last_due0, last_due1;
  int   ovr_cyc0, ovr_cyc1;
  exp_t qs0[$], qs1[$];
  int   qv0[$], qv1[$];

  // Monitor state.
  logic [K-1:0] held0, held1, first0;
  int           bu0, bu1;
  bit           seen0;

  mca_s_frame_ctrl #(.K(K), .MCA_NUM_ADDITIONS(A), .DECIMATION(D0), .RESULT_LATENCY(L)) u_dut0 (
    .clk(clk), .resetn(resetn), .s_in(s_in), .s_valid(s_valid),
    .S_matrix(s0_S), .start(s0_start), .busy(s0_busy),
    .sample_valid(s0_sv), .overrun(s0_ovr)
  );

  mca_s_frame_ctrl #(.K(K), .MCA_NUM_ADDITIONS(A), .DECIMATION(D1), .RESULT_LATENCY(L)) u_dut1 (
    .clk(clk), .resetn(resetn), .s_in(s_in), .s_valid(s_valid),
    .S_matrix(s1_S), .start(s1_start), .busy(s1_busy),
    .sample_valid(s1_sv), .overrun(s1_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    n_acc     = 0;
    last_due0 = -1000;
    last_due1 = -1000;
    ovr_cyc0  = -1;
    ovr_cyc1  = -1;
    qs0.delete(); qs1.delete();
    qv0.delete(); qv1.delete();
  endtask

  // Frame bookkeeping for one instance: accept if the previous frame's hold
  // window (A cycles after its start) has ended by this cycle, else drop.
  task automatic frame_due(input int inst, input logic [K-1:0] snap);
    exp_t e;
    e.snap = snap;
    e.cyc  = cyc + 1;
    if (inst == 0) begin
      if (cyc - last_due0 >= A) begin
        qs0.push_back(e); qv0.push_back(cyc + 1 + L); last_due0 = cyc;
      end else if (ovr_cyc0 < 0) begin
        ovr_cyc0 = cyc + 1;
      end
    end else begin
      if (cyc - last_due1 >= A) begin
        qs1.push_back(e); qv1.push_back(cyc + 1 + L); last_due1 = cyc;
      end else if (ovr_cyc1 < 0) begin
        ovr_cyc1 = cyc + 1;
      end
    end
  endtask

  // Drive one cycle of input and update the model for it.
  task automatic push_bit(input bit b, input bit v);
    logic [K-1:0] snap;
    int pos;
    @(posedge clk); #1;
    s_valid = v;
    s_in    = b;
    if (v) begin
      hist.push_back(b);
      if (hist.size() > K) void'(hist.pop_front());
      n_acc++;
      if (n_acc >= K) begin
        for (int j = 0; j < K; j++) snap[j] = hist[hist.size() - 1 - j];
        pos = n_acc - K;
        if (pos % D0 == D0 - 1) frame_due(0, snap);
        if (pos % D1 == D1 - 1) frame_due(1, snap);
      end
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk); #1;
    resetn  = 1'b0;
    s_valid = 1'b0;
    model_clear();
    #1;
    chk("rst_S0", 32'(s0_S), 0);
    chk("rst_start0", 32'(s0_start), 0);
    chk("rst_busy0", 32'(s0_busy), 0);
    chk("rst_sv0", 32'(s0_sv), 0);
    chk("rst_ovr0", 32'(s0_ovr), 0);
    chk("rst_busy1", 32'(s1_busy), 0);
    chk("rst_ovr1", 32'(s1_ovr), 0);
    repeat (ncyc) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: pops expected frames/pulses when the DUT presents them.
  always @(negedge clk) begin
    if (!resetn) begin
      held0 = '0; held1 = '0; bu0 = -1; bu1 = -1;
    end else begin
      exp_t e;
      if (s0_start) begin
        if (qs0.size() == 0) chk("start0_unexpected", 1, 0);
        else begin
          e = qs0.pop_front();
          chk("start0_cyc", cyc, e.cyc);
          chk("snap0", 32'(s0_S), 32'(e.snap));
          held0 = e.snap; bu0 = e.cyc + A - 1;
          if (!seen0) begin first0 = s0_S; seen0 = 1'b1; end
        end
      end else if (qs0.size() != 0 && qs0[0].cyc < cyc) begin
        chk("start0_missing", 0, 1); void'(qs0.pop_front());
      end
      if (s1_start) begin
        if (qs1.size() == 0) chk("start1_unexpected", 1, 0);
        else begin
          e = qs1.pop_front();
          chk("start1_cyc", cyc, e.cyc);
          chk("snap1", 32'(s1_S), 32'(e.snap));
          held1 = e.snap; bu1 = e.cyc + A - 1;
        end
      end else if (qs1.size() != 0 && qs1[0].cyc < cyc) begin
        chk("start1_missing", 0, 1); void'(qs1.pop_front());
      end
      if (s0_sv) begin
        if (qv0.size() == 0) chk("sv0_unexpected", 1, 0);
        else chk("sv0_cyc", cyc, qv0.pop_front());
      end else if (qv0.size() != 0 && qv0[0] < cyc) begin
        chk("sv0_missing", 0, 1); void'(qv0.pop_front());
      end
      if (s1_sv) begin
        if (qv1.size() == 0) chk("sv1_unexpected", 1, 0);
        else chk("sv1_cyc", cyc, qv1.pop_front());
      end else if (qv1.size() != 0 && qv1[0] < cyc) begin
        chk("sv1_missing", 0, 1); void'(qv1.pop_front());
      end
      chk("hold0", 32'(s0_S), 32'(held0));
      chk("hold1", 32'(s1_S), 32'(held1));
      chk("busy0", 32'(s0_busy), (cyc <= bu0) ? 1 : 0);
      chk("busy1", 32'(s1_busy), (cyc <= bu1) ? 1 : 0);
      chk("ovr0", 32'(s0_ovr), (ovr_cyc0 >= 0 && cyc >= ovr_cyc0) ? 1 : 0);
      chk("ovr1", 32'(s1_ovr), (ovr_cyc1 >= 0 && cyc >= ovr_cyc1) ? 1 : 0);
    end
  end

  initial begin
    bit got_busy;
    seen0 = 1'b0;
    model_clear();
    do_reset(2);

    // Fill with alternating bits starting at 1; no frame before K bits.
    for (int i = 0; i < 15; i++) push_bit((i % 2) == 0, 1'b1);
    @(negedge clk);
    chk("fill_no_start", 32'(seen0), 0);
    chk("fill_busy0", 32'(s0_busy), 0);
    for (int i = 15; i < 40; i++) push_bit((i % 2) == 0, 1'b1);
    chk("first_snap", 32'(first0), 32'h5555);

    // Gapped input: valid every third cycle.
    for (int i = 0; i < 240; i++) push_bit(1'($urandom), (i % 3) == 0);

    // Random valid density and data.
    for (int i = 0; i < 300; i++) push_bit(1'($urandom), ($urandom % 4) != 0);

    // Reset while the normal instance holds a frame.
    got_busy = 1'b0;
    for (int i = 0; i < 100 && !got_busy; i++) begin
      push_bit(1'($urandom), 1'b1);
      @(negedge clk);
      got_busy = s0_busy;
    end
    chk("wait_busy0", 32'(got_busy), 1);
    do_reset(2);

    // Refill and run continuously with random data.
    for (int i = 0; i < 200; i++) push_bit(1'($urandom), 1'b1);

    // Drain the latency pipe.
    for (int i = 0; i < L + A + 5; i++) push_bit(1'b0, 1'b0);
    @(negedge clk);
    chk("drain_qs0", qs0.size(), 0);
    chk("drain_qv0", qv0.size(), 0);
    chk("drain_qs1", qs1.size(), 0);
    chk("drain_qv1", qv1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
